// File: rtl/seq_pattern_pkg.sv
// seq_pattern_pkg: shared state encoding and defaults for the serial pattern
// generator (seq_pattern_tx) and its optional self-check detector.
package seq_pattern_pkg;

  // FSM encoding, also exported on the state_dbg port of seq_pattern_tx.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Pattern used by the detectors this block drives, for convenience in benches.
  localparam logic [3:0] DEF_PAT = 4'b1101;

endpackage

// File: rtl/seq_tx_selfcheck.sv
// seq_tx_selfcheck: overlapping detector for an arbitrary PAT_W-bit pattern.
// It keeps the last PAT_W qualified bits and a fill count, and increments a
// saturating match counter whenever the window equals the pattern.
// Built only when SEQ_PATTERN_TX_SELFCHECK_EN is defined.
`ifdef SEQ_PATTERN_TX_SELFCHECK_EN
module seq_tx_selfcheck #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [PAT_W-1:0] pat,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  hist_nxt;
  logic              full_nxt;
  logic              hit;

  // Window after accepting the current bit; a hit needs PAT_W bits seen.
  always_comb begin
    hist_nxt = {hist[PAT_W-2:0], bit_in};
    full_nxt = (fill >= FILL_W'(PAT_W - 1));
    hit      = bit_valid && full_nxt && (hist_nxt == pat);
  end

  // Shift qualified bits in and count matches, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
    end else if (bit_valid) begin
      hist <= hist_nxt;
      if (fill != FILL_W'(PAT_W)) fill <= fill + 1'b1;
      if (hit && (match_cnt != '1)) match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern generator. Sends a latched PAT_W-bit pattern
// MSB first, a given number of times, with optional idle gaps in between.
// Optional self-check detector: define SEQ_PATTERN_TX_SELFCHECK_EN.
//
// Start handshake: the request (pat_in, rep_count, gap_cycles) is taken in the
// cycle where start_valid && start_ready are both high at the rising edge;
// start_ready is high only in IDLE and requests at other times are dropped.
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] rep_count,
  input  logic [GAP_W-1:0] gap_cycles,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output state_t           state_dbg
);

  localparam int              IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] reps_left;
  logic [GAP_W-1:0] gap_len;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] reps_norm;

  // A repeat count of zero sends the pattern once.
  always_comb begin
    reps_norm = (rep_count == '0) ? CNT_W'(1) : rep_count;
  end

  // Main FSM; every output is registered together with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pat_q       <= '0;
      idx         <= '0;
      reps_left   <= '0;
      gap_len     <= '0;
      gap_cnt     <= '0;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            pat_q       <= pat_in;
            reps_left   <= reps_norm;
            gap_len     <= gap_cycles;
            idx         <= IDX_MSB;
            state       <= ST_SHIFT;
            out         <= pat_in[PAT_W-1];
            out_valid   <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
            start_ready <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (idx != '0) begin
            idx         <= idx - 1'b1;
            out         <= pat_q[idx - 1'b1];
            frame_start <= 1'b0;
          end else if (reps_left != CNT_W'(1)) begin
            // More repetitions: either pause for the gap or restart with no bubble.
            reps_left <= reps_left - 1'b1;
            if (gap_len != '0) begin
              state       <= ST_GAP;
              gap_cnt     <= gap_len;
              out         <= 1'b0;
              out_valid   <= 1'b0;
              frame_start <= 1'b0;
            end else begin
              idx         <= IDX_MSB;
              out         <= pat_q[PAT_W-1];
              frame_start <= 1'b1;
            end
          end else begin
            reps_left   <= '0;
            state       <= ST_DONE;
            out         <= 1'b0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b1;
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            state       <= ST_SHIFT;
            idx         <= IDX_MSB;
            out         <= pat_q[PAT_W-1];
            out_valid   <= 1'b1;
            frame_start <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        ST_DONE: begin
          state       <= ST_IDLE;
          done        <= 1'b0;
          busy        <= 1'b0;
          start_ready <= 1'b1;
        end

        default: begin
          state       <= ST_IDLE;
          out         <= 1'b0;
          out_valid   <= 1'b0;
          frame_start <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          start_ready <= 1'b1;
        end
      endcase
    end
  end

  // Debug view of the FSM.
  always_comb begin
    state_dbg = state;
  end

`ifdef SEQ_PATTERN_TX_SELFCHECK_EN
  logic accept;

  // Accept strobe clears the detector for the new frame.
  always_comb begin
    accept = (state == ST_IDLE) && start_valid;
  end

  seq_tx_selfcheck #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) u_selfcheck (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .pat       (pat_q),
    .bit_in    (out),
    .bit_valid (out_valid),
    .match_cnt (match_cnt)
  );
`else
  // Without the detector the match count stays at zero.
  always_comb begin
    match_cnt = '0;
  end
`endif

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed bench for seq_pattern_tx with hand-computed
// serial streams; inputs are driven and outputs sampled 1 time unit after
// each rising edge.
module tb_seq_pattern_tx;
  import seq_pattern_pkg::*;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [PAT_W-1:0] pat_in;
  logic [CNT_W-1:0] rep_count;
  logic [GAP_W-1:0] gap_cycles;
  logic             out;
  logic             out_valid;
  logic             frame_start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_cnt;
  state_t           state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .pat_in      (pat_in),
    .rep_count   (rep_count),
    .gap_cycles  (gap_cycles),
    .out         (out),
    .out_valid   (out_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done),
    .match_cnt   (match_cnt),
    .state_dbg   (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept a request in the current (IDLE) cycle, then check n stream cycles
  // against hand vectors (first bit is the MSB of the n-bit field), the done
  // cycle and the return to IDLE. Inputs are scrambled after accept; with hold
  // set, start_valid stays high through the stream to show it is ignored.
  task automatic run(input string tag, input logic [PAT_W-1:0] p,
                     input logic [CNT_W-1:0] r, input logic [GAP_W-1:0] g,
                     input logic [31:0] bits, input logic [31:0] vm,
                     input logic [31:0] fm, input int n, input bit hold);
    chk({tag, ".ready_pre"}, start_ready, 1);
    pat_in      = p;
    rep_count   = r;
    gap_cycles  = g;
    start_valid = 1'b1;
    tick();
    if (!hold) start_valid = 1'b0;
    pat_in     = ~p;
    rep_count  = 8'd7;
    gap_cycles = 4'd1;
    chk({tag, ".match_clr"}, match_cnt, 0);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.out[%0d]", tag, i), out, bits[n-1-i]);
      chk($sformatf("%s.valid[%0d]", tag, i), out_valid, vm[n-1-i]);
      chk($sformatf("%s.fs[%0d]", tag, i), frame_start, fm[n-1-i]);
      chk($sformatf("%s.busy[%0d]", tag, i), busy, 1);
      chk($sformatf("%s.ready[%0d]", tag, i), start_ready, 0);
      chk($sformatf("%s.done[%0d]", tag, i), done, 0);
      tick();
    end
    start_valid = 1'b0;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".done_valid"}, out_valid, 0);
    chk({tag, ".done_busy"}, busy, 1);
    chk({tag, ".done_ready"}, start_ready, 0);
    tick();
    chk({tag, ".idle_done"}, done, 0);
    chk({tag, ".idle_busy"}, busy, 0);
    chk({tag, ".idle_ready"}, start_ready, 1);
    chk({tag, ".idle_out"}, out, 0);
  endtask

  logic [CNT_W-1:0] exp_match2;
  logic [CNT_W-1:0] exp_match_max;
  int fs_cnt;
  int v_cnt;
  int k;

  // Directed sequence
  initial begin
`ifdef SEQ_PATTERN_TX_SELFCHECK_EN
    exp_match2    = 8'd5;
    exp_match_max = 8'd255;
`else
    exp_match2    = 8'd0;
    exp_match_max = 8'd0;
`endif
    rst = 1'b1; start_valid = 1'b0; pat_in = '0; rep_count = '0; gap_cycles = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.out", out, 0);
    chk("rst.valid", out_valid, 0);
    chk("rst.fs", frame_start, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.ready", start_ready, 1);
    chk("rst.match", match_cnt, 0);
    chk("rst.state", state_dbg, ST_IDLE);

    // Single repetition of the default pattern.
    run("single", DEF_PAT, 8'd1, 4'd0, 32'b1101, 32'b1111, 32'b1000, 4, 1'b0);

    // Three back-to-back repetitions.
    run("b2b3", 4'b1101, 8'd3, 4'd0, 32'b110111011101, 32'hfff,
        32'b100010001000, 12, 1'b0);

    // Two repetitions separated by a 3-cycle gap.
    run("gap3", 4'b1010, 8'd2, 4'd3, 32'b10100001010, 32'b11110001111,
        32'b10000001000, 11, 1'b0);

    // rep_count=0 acts as 1; start_valid held through the frame is ignored.
    run("rep0", 4'b0110, 8'd0, 4'd5, 32'b0110, 32'b1111, 32'b1000, 4, 1'b1);

    // Reset in the second bit of a 3-repetition frame.
    pat_in = 4'b1101; rep_count = 8'd3; gap_cycles = 4'd0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    chk("abort.t1_valid", out_valid, 1);
    chk("abort.t1_fs", frame_start, 1);
    tick();
    chk("abort.t2_out", out, 1);
    chk("abort.t2_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.t3_valid", out_valid, 0);
    chk("abort.t3_done", done, 0);
    chk("abort.t3_busy", busy, 0);
    chk("abort.t3_ready", start_ready, 1);
    chk("abort.t3_state", state_dbg, ST_IDLE);
    run("after_abort", 4'b1010, 8'd1, 4'd0, 32'b1010, 32'b1111, 32'b1000, 4, 1'b0);

    // Reset and start in the same cycle: request dropped.
    pat_in = 4'b1111; rep_count = 8'd1; start_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; start_valid = 1'b0;
    chk("rst_start.ready", start_ready, 1);
    chk("rst_start.valid", out_valid, 0);
    tick();
    chk("rst_start.valid2", out_valid, 0);
    chk("rst_start.busy2", busy, 0);

    // Overlapping matches of 1111 over two repetitions.
    run("ones2", 4'b1111, 8'd2, 4'd0, 32'hff, 32'hff, 32'b10001000, 8, 1'b0);
    chk("ones2.match", match_cnt, exp_match2);

    // Maximum repeat count: 255 repetitions, 1020 bits, saturated match count.
    pat_in = 4'b1111; rep_count = 8'd255; gap_cycles = 4'd0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    fs_cnt = 0; v_cnt = 0; k = 0;
    while (!done && k < 2000) begin
      if (frame_start) fs_cnt++;
      if (out_valid) v_cnt++;
      k++;
      tick();
    end
    chk("max.done_seen", done, 1);
    chk("max.cycles", k, 1020);
    chk("max.frames", fs_cnt, 255);
    chk("max.bits", v_cnt, 1020);
    tick();
    chk("max.ready", start_ready, 1);
    chk("max.match", match_cnt, exp_match_max);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
